// File: rtl/cordic_twiddle_feeder_pkg.sv
// Shared float32 types and helpers for the CORDIC FFT datapath.
package cordic_fft_pkg;

    typedef logic [31:0] float32_t;

    localparam float32_t FP_ONE  = 32'h3f800000;
    localparam float32_t FP_ZERO = 32'h00000000;

    localparam int unsigned CORDIC_LAT_DEFAULT = 23;

    // Sign flip that never produces -0: any zero becomes +0.
    function automatic float32_t fneg(input float32_t v);
        if (v[30:0] == 31'd0) begin
            return FP_ZERO;
        end
        return {~v[31], v[30:0]};
    endfunction

endpackage

// File: rtl/cordic_twiddle_feeder_if.sv
// Sample/operand bus of the twiddle feeder; i_inverse exists only with TWIDDLE_CONJ_EN.
interface cordic_twiddle_feeder_if #(
    parameter int unsigned KW = 4
);
    import cordic_fft_pkg::*;

    logic           i_start;
    logic [KW-1:0]  i_stride;
    logic           i_valid;
    float32_t       i_x;
    float32_t       i_y;
    logic [KW-1:0]  i_k;
`ifdef TWIDDLE_CONJ_EN
    logic           i_inverse;
`endif
    float32_t       o_x;
    float32_t       o_y;
    float32_t       o_z;
    logic           o_valid;
    logic           o_res_valid;
    logic [KW-1:0]  o_res_k;
    logic           o_busy;
    logic           o_frame_done;

    modport master (
`ifdef TWIDDLE_CONJ_EN
        output i_inverse,
`endif
        output i_start, i_stride, i_valid, i_x, i_y, i_k,
        input  o_x, o_y, o_z, o_valid, o_res_valid, o_res_k, o_busy, o_frame_done
    );

    modport slave (
`ifdef TWIDDLE_CONJ_EN
        input  i_inverse,
`endif
        input  i_start, i_stride, i_valid, i_x, i_y, i_k,
        output o_x, o_y, o_z, o_valid, o_res_valid, o_res_k, o_busy, o_frame_done
    );

endinterface

// File: rtl/cordic_twiddle_feeder_rom.sv
// Synchronous N_POINTS/4 x 32 ROM of residual angles -2*pi*r/N_POINTS as float32.
module twiddle_rom
    import cordic_fft_pkg::*;
#(
    parameter  int unsigned N_POINTS = 16,
    localparam int unsigned KW       = $clog2(N_POINTS),
    localparam int unsigned AW       = KW - 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [AW-1:0] addr,
    output float32_t      data
);

    localparam int unsigned DEPTH = N_POINTS / 4;
    // pi scaled by 2^61
    localparam logic [63:0] PI_FX = 64'h6487ED5110B4611A;

    // Builds the float32 image of -2*pi*r/N_POINTS, rounded to nearest even.
    function automatic float32_t angle_bits(input int unsigned r);
        logic [63:0]  mag;
        logic [63:0]  nrm;
        logic [30:0]  em;
        logic         round_up;
        int unsigned  p;
        mag = (PI_FX >> (KW - 1)) * 64'(r);
        if (mag == 64'd0) begin
            return FP_ZERO;
        end
        p = 0;
        for (int unsigned i = 0; i < 64; i++) begin
            if (mag[i]) p = i;
        end
        nrm      = mag << (63 - p);
        em       = {8'(127 + p - 61), nrm[62:40]};
        round_up = nrm[39] && (nrm[40] || (nrm[38:0] != 39'd0));
        return {1'b1, em + 31'(round_up)};
    endfunction

    float32_t rom_tbl [DEPTH];

    for (genvar a = 0; a < DEPTH; a++) begin : g_tbl
        assign rom_tbl[a] = angle_bits(a);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data <= FP_ZERO;
        end else begin
            data <= rom_tbl[addr];
        end
    end

endmodule

// File: rtl/cordic_twiddle_feeder.sv
// Folds (sample, twiddle index) into CORDIC operands with |z| <= pi/2 and tracks valid/k tags.
// Optional TWIDDLE_CONJ_EN adds bus.i_inverse for the inverse (conjugate) rotation.
module cordic_twiddle_feeder
    import cordic_fft_pkg::*;
#(
    parameter int unsigned N_POINTS   = 16,
    parameter int unsigned CORDIC_LAT = CORDIC_LAT_DEFAULT,
    parameter              ROM_FILE   = "twiddle.hex"
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    cordic_twiddle_feeder_if.slave bus
);

    localparam int unsigned KW = $clog2(N_POINTS);

    localparam bit CFG_OK = (N_POINTS >= 8) && ((N_POINTS & (N_POINTS - 1)) == 0) &&
                            (CORDIC_LAT >= 1) && ($bits(ROM_FILE) >= 8);
    if (!CFG_OK) begin : g_bad_cfg
        $error("cordic_twiddle_feeder: unsupported parameter set");
    end

    typedef enum logic {IDLE, RUN} state_t;

    state_t         state;
    logic [KW-1:0]  cnt;
    logic [KW-1:0]  stride_q;
    logic           busy_q;
    logic           done_q;
    logic [KW-1:0]  k_run_c;
    logic [KW-1:0]  k_c;

    logic           s1_valid;
    logic [KW-1:0]  s1_k;
    float32_t       s1_x;
    float32_t       s1_y;
    float32_t       rom_data;
`ifdef TWIDDLE_CONJ_EN
    logic           s1_inv;
`endif

    logic [1:0]     q_c;
    float32_t       fx_c;
    float32_t       fy_c;
    float32_t       fz_c;

    logic           valid_q;
    logic [KW-1:0]  s2_k;
    float32_t       x_q;
    float32_t       y_q;
    float32_t       z_q;

    logic [CORDIC_LAT-1:0] vld_sr;
    logic [KW-1:0]         k_sr [CORDIC_LAT];

    // Truncation to KW bits is the modulo-N_POINTS reduction.
    assign k_run_c = cnt * stride_q;
    assign k_c     = (state == RUN) ? k_run_c : bus.i_k;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state    <= IDLE;
            cnt      <= '0;
            stride_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.i_start) begin
                        state    <= RUN;
                        cnt      <= '0;
                        stride_q <= bus.i_stride;
                        busy_q   <= 1'b1;
                    end
                end
                RUN: begin
                    if (bus.i_valid) begin
                        cnt <= cnt + KW'(1);
                        if (cnt == KW'(N_POINTS - 1)) begin
                            state  <= IDLE;
                            busy_q <= 1'b0;
                            done_q <= 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    twiddle_rom #(
        .N_POINTS (N_POINTS)
    ) u_rom (
        .clk  (i_clk),
        .rst  (i_reset),
        .addr (k_c[KW-3:0]),
        .data (rom_data)
    );

    // Stage 1: capture sample and index alongside the ROM read.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            s1_valid <= 1'b0;
            s1_k     <= '0;
            s1_x     <= FP_ZERO;
            s1_y     <= FP_ZERO;
`ifdef TWIDDLE_CONJ_EN
            s1_inv   <= 1'b0;
`endif
        end else begin
            s1_valid <= bus.i_valid;
            if (bus.i_valid) begin
                s1_k <= k_c;
                s1_x <= bus.i_x;
                s1_y <= bus.i_y;
`ifdef TWIDDLE_CONJ_EN
                s1_inv <= bus.i_inverse;
`endif
            end
        end
    end

    assign q_c = s1_k[KW-1:KW-2];

    // Quadrant pre-rotation by swap and sign flip only.
    always_comb begin
        fx_c = s1_x;
        fy_c = s1_y;
        fz_c = rom_data;
        case (q_c)
            2'd1: begin fx_c = s1_y;       fy_c = fneg(s1_x); end
            2'd2: begin fx_c = fneg(s1_x); fy_c = fneg(s1_y); end
            2'd3: begin fx_c = fneg(s1_y); fy_c = s1_x;       end
            default: ;
        endcase
`ifdef TWIDDLE_CONJ_EN
        if (s1_inv) begin
            fz_c = fneg(rom_data);
            if (q_c == 2'd1) begin
                fx_c = fneg(s1_y);
                fy_c = s1_x;
            end else if (q_c == 2'd3) begin
                fx_c = s1_y;
                fy_c = fneg(s1_x);
            end
        end
`endif
    end

    // Stage 2 operand registers; they hold while no sample is present.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            valid_q <= 1'b0;
            s2_k    <= '0;
            x_q     <= FP_ZERO;
            y_q     <= FP_ZERO;
            z_q     <= FP_ZERO;
        end else begin
            valid_q <= s1_valid;
            if (s1_valid) begin
                s2_k <= s1_k;
                x_q  <= fx_c;
                y_q  <= fy_c;
                z_q  <= fz_c;
            end
        end
    end

    // Valid/tag delay matching the CORDIC pipeline.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            vld_sr <= '0;
            for (int i = 0; i < CORDIC_LAT; i++) begin
                k_sr[i] <= '0;
            end
        end else begin
            vld_sr[0] <= valid_q;
            k_sr[0]   <= s2_k;
            for (int i = 1; i < CORDIC_LAT; i++) begin
                vld_sr[i] <= vld_sr[i-1];
                k_sr[i]   <= k_sr[i-1];
            end
        end
    end

    assign bus.o_x          = x_q;
    assign bus.o_y          = y_q;
    assign bus.o_z          = z_q;
    assign bus.o_valid      = valid_q;
    assign bus.o_res_valid  = vld_sr[CORDIC_LAT-1];
    assign bus.o_res_k      = k_sr[CORDIC_LAT-1];
    assign bus.o_busy       = busy_q;
    assign bus.o_frame_done = done_q;

endmodule
